// File: rtl/store_buffer_pkg.sv
// Shared types for the MEM-stage store buffer:
// data_mem func codes, queue entry, alignment helper.
package store_buffer_pkg;

  localparam logic [2:0] F_WORD  = 3'b000;
  localparam logic [2:0] F_HALF  = 3'b001;
  localparam logic [2:0] F_BYTE  = 3'b010;
  localparam logic [2:0] F_HALFU = 3'b101;
  localparam logic [2:0] F_BYTEU = 3'b110;

  typedef struct packed {
    logic [2:0]  func;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sb_entry_t;

  function automatic logic is_misaligned(
    input logic [2:0] f,
    input logic [1:0] a
  );
    is_misaligned = 1'b0;
    case (f)
      F_WORD:          is_misaligned = |a;
      F_HALF, F_HALFU: is_misaligned = a[0];
      default:         is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_sb_fifo.sv
// Circular store queue with a parallel
// word-index compare against all live entries.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  sb_entry_t     din,
  input  logic [AW-3:0] cmp_idx,
  output sb_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic          hit
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   C_ONE  = 1;
  localparam logic [PW:0]   C_FULL = DEPTH[PW:0];
  localparam logic [PW-1:0] P_ONE  = 1;

  sb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    hd;
  logic [PW-1:0]    tl;
  logic [PW:0]      cnt;

  assign head  = mem[hd];
  assign full  = (cnt == C_FULL);
  assign empty = (cnt == '0);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && mem[i].addr[AW-1:2] == cmp_idx)
        hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd  <= '0;
      tl  <= '0;
      cnt <= '0;
      vld <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tl] <= din;
        vld[tl] <= 1'b1;
        tl      <= tl + P_ONE;
      end
      if (pop) begin
        vld[hd] <= 1'b0;
        hd      <= hd + P_ONE;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + C_ONE;
        2'b01:   cnt <= cnt - C_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/store_buffer.sv
// MEM-stage write buffer owning the data_mem port:
// queues stores, retires them on idle/blocked cycles.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_func,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic [31:0] req_rdata,
  output logic        misalign,
  input  logic        fence,
  output logic        sb_empty,
  output logic [2:0]  dm_func,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout
);

  sb_entry_t head;
  sb_entry_t din;
  logic      full;
  logic      empty;
  logic      hit;
  logic      push;
  logic      pop;
  logic      load;
  logic      mis;

  assign din = '{func: req_func, addr: req_addr, wdata: req_wdata};

  sb_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .din     (din),
    .cmp_idx (req_addr[AW-1:2]),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .hit     (hit)
  );

  assign mis = rst_n & req_valid & ~fence
             & is_misaligned(req_func, req_addr[1:0]);
  assign misalign = mis;
  assign sb_empty = empty;

  // Requests are ignored while reset is held so no port activity leaks out.
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    load      = 1'b0;
    req_ready = 1'b1;
    if (!rst_n) begin
      req_ready = 1'b1;
    end else if (fence) begin
      req_ready = 1'b0;
      pop       = ~empty;
    end else if (!req_valid) begin
      pop = ~empty;
    end else if (mis) begin
      req_ready = 1'b1;
    end else if (req_we) begin
      if (!full) begin
        push = 1'b1;
      end else begin
        req_ready = 1'b0;
        pop       = 1'b1;
      end
    end else if (hit) begin
      req_ready = 1'b0;
      pop       = 1'b1;
    end else begin
      load = 1'b1;
    end
  end

  always_comb begin
    dm_we     = pop;
    dm_func   = F_WORD;
    dm_addr   = '0;
    dm_din    = '0;
    req_rdata = '0;
    if (pop) begin
      dm_func = head.func;
      dm_addr = head.addr;
      dm_din  = head.wdata;
    end else if (load) begin
      dm_func   = req_func;
      dm_addr   = req_addr;
      req_rdata = dm_dout;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed + random bench for store_buffer with a
// behavioural data_mem and a program-order reference model.
module tb_store_buffer;

  localparam logic [2:0] WORD  = 3'b000;
  localparam logic [2:0] HALF  = 3'b001;
  localparam logic [2:0] BYTE  = 3'b010;
  localparam logic [2:0] HALFU = 3'b101;
  localparam logic [2:0] BYTEU = 3'b110;
  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0]  func;
    logic [31:0] addr;
    logic [31:0] wdata;
  } st_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_func;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic [31:0] req_rdata;
  logic        misalign;
  logic        fence;
  logic        sb_empty;
  logic [2:0]  dm_func;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;

  logic [31:0] dmem   [256];
  logic [31:0] refmem [256];
  st_t         q [$];
  int          vec;
  int          errs;

  store_buffer #(.DEPTH(DEPTH), .AW(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_func  (req_func),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .req_rdata (req_rdata),
    .misalign  (misalign),
    .fence     (fence),
    .sb_empty  (sb_empty),
    .dm_func   (dm_func),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_din    (dm_din),
    .dm_dout   (dm_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] extract(
    input logic [31:0] w, input logic [2:0] f, input logic [1:0] a);
    logic [15:0] h;
    logic [7:0]  b;
    h = w[{a[1], 4'b0} +: 16];
    b = w[{a, 3'b0} +: 8];
    case (f)
      HALF:    extract = {{16{h[15]}}, h};
      HALFU:   extract = {16'h0, h};
      BYTE:    extract = {{24{b[7]}}, b};
      BYTEU:   extract = {24'h0, b};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] w, input logic [31:0] d,
    input logic [2:0] f, input logic [1:0] a);
    logic [31:0] r;
    r = w;
    case (f)
      HALF, HALFU: r[{a[1], 4'b0} +: 16] = d[15:0];
      BYTE, BYTEU: r[{a, 3'b0} +: 8] = d[7:0];
      default:     r = d;
    endcase
    return r;
  endfunction

  function automatic logic bad_align(input logic [2:0] f, input logic [1:0] a);
    if (f == WORD) return a != 2'b00;
    if (f == HALF || f == HALFU) return a[0];
    return 1'b0;
  endfunction

  assign dm_dout = extract(dmem[dm_addr[9:2]], dm_func, dm_addr[1:0]);

  always @(posedge clk) begin
    if (dm_we)
      dmem[dm_addr[9:2]] <= merge(dmem[dm_addr[9:2]], dm_din, dm_func, dm_addr[1:0]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One cycle: drive, predict from the buffer rules, compare, advance model.
  task automatic step(input logic v, input logic we, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic fn, output logic ok);
    logic e_mis, e_rdy, e_drain, e_load, conflict;
    req_valid = v; req_we = we; req_func = f;
    req_addr = a; req_wdata = d; fence = fn;
    #1;
    conflict = 1'b0;
    foreach (q[i]) if (q[i].addr[9:2] == a[9:2]) conflict = 1'b1;
    e_mis   = v && !fn && bad_align(f, a[1:0]);
    e_drain = 1'b0;
    e_load  = 1'b0;
    e_rdy   = 1'b1;
    if (fn) begin
      e_rdy = 1'b0; e_drain = q.size() > 0;
    end else if (!v) begin
      e_drain = q.size() > 0;
    end else if (e_mis) begin
      e_rdy = 1'b1;
    end else if (we) begin
      e_rdy = q.size() < DEPTH; e_drain = !e_rdy;
    end else begin
      e_rdy = !conflict; e_drain = conflict; e_load = !conflict;
    end
    chk("ready", {31'h0, req_ready}, {31'h0, e_rdy});
    chk("misalign", {31'h0, misalign}, {31'h0, e_mis});
    chk("dm_we", {31'h0, dm_we}, {31'h0, e_drain});
    chk("sb_empty", {31'h0, sb_empty}, {31'h0, q.size() == 0});
    chk("rdata", req_rdata, e_load ? extract(refmem[a[9:2]], f, a[1:0]) : 32'h0);
    if (e_drain) begin
      chk("drain_addr", dm_addr, q[0].addr);
      chk("drain_din", dm_din, q[0].wdata);
      chk("drain_func", {29'h0, dm_func}, {29'h0, q[0].func});
    end
    ok = e_rdy;
    @(posedge clk);
    if (e_drain) begin
      refmem[q[0].addr[9:2]] = merge(refmem[q[0].addr[9:2]], q[0].wdata,
                                     q[0].func, q[0].addr[1:0]);
      void'(q.pop_front());
    end
    if (v && we && !fn && !e_mis && e_rdy) q.push_back('{f, a, d});
    @(negedge clk);
  endtask

  task automatic until_ok(input logic we, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) step(1'b1, we, f, a, d, 1'b0, ok);
    chk("accept_timeout", {31'h0, ok}, 32'h1);
  endtask

  task automatic idle(input int n);
    logic ok;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, WORD, 32'h0, 32'h0, 1'b0, ok);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_dm_we"}, {31'h0, dm_we}, 32'h0);
    chk({tag, "_dm_addr"}, dm_addr, 32'h0);
    chk({tag, "_dm_din"}, dm_din, 32'h0);
    chk({tag, "_dm_func"}, {29'h0, dm_func}, {29'h0, WORD});
    chk({tag, "_rdata"}, req_rdata, 32'h0);
    chk({tag, "_misalign"}, {31'h0, misalign}, 32'h0);
    chk({tag, "_empty"}, {31'h0, sb_empty}, 32'h1);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    logic        ok, v, we, fn;
    logic [2:0]  f;
    logic [31:0] a, d;
    logic [2:0]  lf [5];
    logic [2:0]  sf [3];
    lf = '{WORD, HALF, BYTE, HALFU, BYTEU};
    sf = '{WORD, HALF, BYTE};
    vec = 0; errs = 0;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      dmem[i] = d;
      refmem[i] = d;
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_func = WORD;
    req_addr = 32'h0; req_wdata = 32'h0; fence = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_check("reset");
    rst_n = 1'b1;
    @(negedge clk);

    step(1'b1, 1'b1, WORD, 32'h10, 32'h11223344, 1'b0, ok);
    idle(1);
    step(1'b1, 1'b0, WORD, 32'h10, 32'h0, 1'b0, ok);
    chk("lw_after_sw", req_rdata, 32'h11223344);

    step(1'b1, 1'b1, BYTE, 32'h13, 32'hAB, 1'b0, ok);
    step(1'b1, 1'b0, WORD, 32'h10, 32'h0, 1'b0, ok);
    chk("conflict_stall", {31'h0, ok}, 32'h0);
    until_ok(1'b0, WORD, 32'h10, 32'h0);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, WORD, i * 4, $urandom, 1'b0, ok);
    step(1'b1, 1'b1, WORD, 32'h40, 32'hCAFE0040, 1'b0, ok);
    chk("full_stall", {31'h0, ok}, 32'h0);
    until_ok(1'b1, WORD, 32'h40, 32'hCAFE0040);
    idle(6);

    step(1'b1, 1'b1, HALF, 32'h30, 32'h5A5A, 1'b0, ok);
    step(1'b1, 1'b0, WORD, 32'h22, 32'h0, 1'b0, ok);
    step(1'b1, 1'b0, HALF, 32'h21, 32'h0, 1'b0, ok);
    step(1'b1, 1'b1, WORD, 32'h31, 32'h1, 1'b0, ok);
    idle(2);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, WORD, i * 4, 32'hF0 + i, 1'b0, ok);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, WORD, 32'h80, 32'h0, 1'b1, ok);
    chk("fence_empty", {31'h0, sb_empty}, 32'h1);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, WORD, 32'h20 + i * 4, 32'hD0 + i, 1'b0, ok);
    idle(1);
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h44;
    #1;
    reset_check("midreset");
    q.delete();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, WORD, 32'h24, 32'h0, 1'b0, ok);
    step(1'b1, 1'b0, WORD, 32'h20, 32'h0, 1'b0, ok);

    ok = 1'b1;
    v = 1'b0; we = 1'b0; f = WORD; a = 32'h0; d = 32'h0; fn = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (ok || !v) begin
        v  = $urandom_range(0, 3) != 0;
        we = $urandom_range(0, 1) != 0;
        f  = we ? sf[$urandom_range(0, 2)] : lf[$urandom_range(0, 4)];
        a  = {26'h0, 6'($urandom_range(0, 63))};
        d  = $urandom;
      end
      fn = $urandom_range(0, 9) == 0;
      step(v, we, f, a, d, fn, ok);
    end
    idle(DEPTH + 1);
    chk("final_empty", {31'h0, sb_empty}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
